memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, sets the word width.
REQ-002 Parameter ADDR_W, default 3, sets the address width; depth is 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester transfer request; bit i belongs to requester i.
REQ-006 req_save  input  2  per-requester direction: 1 = write (save), 0 = read.
REQ-007 req_lock  input  2  per-requester request to keep ownership after this transfer.
REQ-008 req_addr  input  2*ADDR_W  per-requester address; requester i uses slice i.
REQ-009 req_value  input  2*DATA_W  per-requester write data; requester i uses slice i.
REQ-010 req_ready  output  2  one-hot grant; the transfer is accepted when req_valid[i] & req_ready[i].
REQ-011 rsp_valid  output  2  one-cycle read-response strobe, per requester.
REQ-012 rsp_data  output  DATA_W  read data, valid only when a rsp_valid bit is set.

Function
REQ-013 req_ready shall be combinational from req_valid, arbiter state and reset, with at most one bit set.
REQ-014 req_ready[i] shall never be 1 while req_valid[i] is 0.
REQ-015 In state FREE with exactly one valid requester, that requester shall be granted.
REQ-016 In state FREE with both valid, the requester not granted most recently shall be granted (round-robin pointer last_grant).
REQ-017 last_grant shall update to i on every accepted transfer of requester i.
REQ-018 In state LOCKED(i), only requester i shall be granted; the other requester's ready stays 0 even while req_valid[i] is 0.
REQ-019 State FREE shall go to LOCKED(i) on an accepted transfer of i with req_lock[i]=1.
REQ-020 State LOCKED(i) shall go to FREE on an accepted transfer of i with req_lock[i]=0.
REQ-021 An accepted write shall update mem[addr] at that edge and produce no response.
REQ-022 An accepted read shall set rsp_valid[i]=1 and rsp_data=mem[addr] exactly one cycle later (latency 1), for one cycle.
REQ-023 A read accepted in the cycle after a write to the same address shall return the newly written value.
REQ-024 With no accepted read in a cycle, rsp_valid shall be 0 in the next cycle and rsp_data shall hold its last value.
REQ-025 Back-to-back accepted reads shall produce back-to-back responses, one per cycle, with no bubbles.

Reset
REQ-026 While reset=1, req_ready shall be 00.
REQ-027 On the edge sampling reset=1: state=FREE, last_grant=1 (so requester 0 wins the first tie), rsp_valid=00, rsp_data=0, all memory words=0.
REQ-028 Reset asserted mid-lock or with a read in flight shall discard the lock and suppress the pending response.

Structure
REQ-029 Package memory_arbiter_pkg shall hold the DATA_W/ADDR_W defaults and the state enum {FREE, LOCKED0, LOCKED1}.
REQ-030 Storage shall be a sub-module mem_bank: single port, synchronous write, registered read, synchronous clear.
REQ-031 The arbitration, lock FSM and response tagging shall reside in memory_arbiter.

Verification
REQ-032 Write/read: after reset, requester 0 writes 0xA5 to addr 3, then reads addr 3 -> rsp_valid=01 and rsp_data=0xA5 one cycle after the read is accepted.
REQ-033 Contention: both requesters read continuously in FREE -> grants alternate 01,10,01,10 starting with 01.
REQ-034 Lock: requester 1 writes with lock=1, then idles 3 cycles while requester 0 is valid -> req_ready[0]=0 throughout; a lock=0 transfer from 1 frees the arbiter and 0 is granted next cycle.
REQ-035 Reset mid-operation: reset asserted in the cycle after an accepted read while LOCKED1 -> no rsp_valid, state FREE, read of any address returns 0x00.
REQ-036 Read-after-write: requester 1 writes 0x3C to addr 7, requester 0 reads addr 7 the next cycle -> rsp_valid=01 and rsp_data=0x3C.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// memory_arbiter_pkg
// Shared definitions for the two-requester memory arbiter:
//   DEF_DATA_W / DEF_ADDR_W : default word and address widths
//   arb_state_e             : ownership state of the arbiter
//   lock_state()            : maps a requester index to its LOCKED state
// ---------------------------------------------------------------------------
package memory_arbiter_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        LOCKED0 = 2'd1,
        LOCKED1 = 2'd2
    } arb_state_e;

    function automatic arb_state_e lock_state(input logic owner);
        return owner ? LOCKED1 : LOCKED0;
    endfunction

endpackage

// File: rtl/memory_arbiter_mem.sv
// ---------------------------------------------------------------------------
// mem_bank
// Single-port storage behind the arbiter.
//   clk    : clock, all updates on the rising edge
//   reset  : synchronous active-high; clears every word and the read register
//   en     : a transfer is presented this cycle
//   we     : 1 = write wdata to addr, 0 = read addr
//   addr   : word address
//   wdata  : write data
//   rdata  : registered read data; holds its value when no read is performed
// ---------------------------------------------------------------------------
module mem_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
// Two requesters share one single-port memory. Grants are round-robin while
// the arbiter is free; a requester can hold ownership across transfers with
// req_lock. Reads answer one cycle after acceptance on rsp_valid/rsp_data.
//
// Ports
//   clk        : clock
//   reset      : synchronous active-high reset
//   req_valid  : [1:0] per-requester transfer request
//   req_save   : [1:0] per-requester direction, 1 = write, 0 = read
//   req_lock   : [1:0] keep ownership after this transfer
//   req_addr   : [2*ADDR_W-1:0] requester i uses slice i
//   req_value  : [2*DATA_W-1:0] requester i uses slice i
//   req_ready  : [1:0] one-hot grant, combinational
//   rsp_valid  : [1:0] one-cycle read-response strobe
//   rsp_data   : read data, meaningful while a rsp_valid bit is set
//
// State table
//   state   | meaning
//   FREE    | no owner; grant round-robin on last_grant
//   LOCKED0 | requester 0 owns the memory; requester 1 is held off
//   LOCKED1 | requester 1 owns the memory; requester 0 is held off
// ---------------------------------------------------------------------------
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_save,
    input  logic [1:0]          req_lock,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_value,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_data
);

    arb_state_e        state;
    logic              last_grant;
    logic [1:0]        grant;
    logic [1:0]        accept;
    logic [1:0]        rsp_valid_q;
    logic              xfer;
    logic              sel;
    logic              sel_save;
    logic              sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_value;

    // Grant only to requesters that are asking, so ready never leads valid.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            case (state)
                FREE: begin
                    case (req_valid)
                        2'b01:   grant = 2'b01;
                        2'b10:   grant = 2'b10;
                        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                        default: grant = 2'b00;
                    endcase
                end
                LOCKED0: grant = {1'b0, req_valid[0]};
                LOCKED1: grant = {req_valid[1], 1'b0};
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign accept    = req_valid & grant;
    assign xfer      = |accept;
    assign sel       = accept[1];

    assign sel_save  = sel ? req_save[1] : req_save[0];
    assign sel_lock  = sel ? req_lock[1] : req_lock[0];
    assign sel_addr  = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign sel_value = sel ? req_value[2*DATA_W-1:DATA_W] : req_value[DATA_W-1:0];

    // While locked only the owner can be accepted, so sel is the owner there.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FREE;
            last_grant  <= 1'b1;
            rsp_valid_q <= 2'b00;
        end else begin
            rsp_valid_q <= (xfer && !sel_save) ? accept : 2'b00;
            if (xfer) begin
                last_grant <= sel;
                case (state)
                    FREE: begin
                        if (sel_lock) begin
                            state <= lock_state(sel);
                        end
                    end
                    LOCKED0, LOCKED1: begin
                        if (!sel_lock) begin
                            state <= FREE;
                        end
                    end
                    default: state <= FREE;
                endcase
            end
        end
    end

    // A response already in its output cycle is withdrawn when reset arrives.
    assign rsp_valid = rsp_valid_q & {2{~reset}};

    mem_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_bank (
        .clk   (clk),
        .reset (reset),
        .en    (xfer),
        .we    (sel_save),
        .addr  (sel_addr),
        .wdata (sel_value),
        .rdata (rsp_data)
    );

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0]          req_valid;
    logic [1:0]          req_save;
    logic [1:0]          req_lock;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_value;
    logic [1:0]          req_ready;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_data;

    typedef struct {
        logic [1:0] who;
        logic [7:0] data;
        int         due;
    } rsp_t;

    rsp_t       sb[$];
    logic [7:0] mdl [8];
    int         cyc    = 0;
    int         n_cmp  = 0;
    int         n_fail = 0;

    memory_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_save  (req_save),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_value (req_value),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: every negedge either the scoreboard head is due or
    // no response may be present.
    always @(negedge clk) begin
        rsp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rsp_valid", {6'b0, rsp_valid}, {6'b0, e.who});
            chk("rsp_data", rsp_data, e.data);
        end else begin
            chk("rsp_idle", {6'b0, rsp_valid}, 8'h00);
        end
    end

    // Drive one cycle of requests (called at posedge+1), check the grant,
    // update the model and push expected read responses.
    task automatic drive(input logic [1:0] v, input logic [1:0] s, input logic [1:0] l,
                         input logic [2:0] a0, input logic [2:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [1:0] exp, input string tag);
        rsp_t       e;
        int         k;
        logic [2:0] a;
        logic [7:0] d;
        req_valid = v;
        req_save  = s;
        req_lock  = l;
        req_addr  = {a1, a0};
        req_value = {d1, d0};
        #1;
        chk(tag, {6'b0, req_ready}, {6'b0, exp});
        if ((v & exp) != 2'b00) begin
            k = exp[1] ? 1 : 0;
            a = (k == 1) ? a1 : a0;
            d = (k == 1) ? d1 : d0;
            if (s[k]) begin
                mdl[a] = d;
            end else begin
                e.who  = exp;
                e.data = mdl[a];
                e.due  = cyc + 1;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        sb.delete();
    endtask

    task automatic apply_reset(input int cycles);
        reset     = 1'b1;
        req_valid = 2'b11;
        req_save  = 2'b00;
        req_lock  = 2'b11;
        sb.delete();
        #1;
        chk("ready_in_reset", {6'b0, req_ready}, 8'h00);
        chk("rsp_in_reset", {6'b0, rsp_valid}, 8'h00);
        repeat (cycles) @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 2'b00;
        req_lock  = 2'b00;
        clear_model();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 2'b00;
        req_save  = 2'b00;
        req_lock  = 2'b00;
        req_addr  = '0;
        req_value = '0;
        clear_model();

        // Reset state
        apply_reset(2);
        chk("rsp_data_reset", rsp_data, 8'h00);

        // Write/read by requester 0
        drive(2'b01, 2'b01, 2'b00, 3'd3, 3'd0, 8'hA5, 8'h00, 2'b01, "wr0_a3");
        drive(2'b01, 2'b00, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00, 2'b01, "rd0_a3");
        drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, "idle0");
        chk("rsp_hold", rsp_data, 8'hA5);

        // Contention from a fresh reset, after one write each
        apply_reset(1);
        drive(2'b01, 2'b01, 2'b00, 3'd2, 3'd0, 8'h5A, 8'h00, 2'b01, "wr0_a2");
        drive(2'b10, 2'b10, 2'b00, 3'd0, 3'd1, 8'h00, 8'h11, 2'b10, "wr1_a1");
        drive(2'b11, 2'b00, 2'b00, 3'd2, 3'd1, 8'h00, 8'h00, 2'b01, "rr_1");
        drive(2'b11, 2'b00, 2'b00, 3'd2, 3'd1, 8'h00, 8'h00, 2'b10, "rr_2");
        drive(2'b11, 2'b00, 2'b00, 3'd2, 3'd1, 8'h00, 8'h00, 2'b01, "rr_3");
        drive(2'b11, 2'b00, 2'b00, 3'd2, 3'd1, 8'h00, 8'h00, 2'b10, "rr_4");

        // Lock held by requester 1
        drive(2'b10, 2'b10, 2'b10, 3'd0, 3'd4, 8'h00, 8'h77, 2'b10, "lock1_wr");
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 2'b00, 2'b00, 3'd4, 3'd0, 8'h00, 8'h00, 2'b00, "locked_hold0");
        end
        drive(2'b11, 2'b00, 2'b10, 3'd4, 3'd4, 8'h00, 8'h00, 2'b10, "locked_rd1");
        drive(2'b11, 2'b10, 2'b00, 3'd4, 3'd5, 8'h00, 8'h99, 2'b10, "unlock1_wr");
        drive(2'b11, 2'b00, 2'b00, 3'd5, 3'd4, 8'h00, 8'h00, 2'b01, "free_gnt0");

        // Reset in the cycle after a read accepted while LOCKED1
        drive(2'b10, 2'b10, 2'b10, 3'd0, 3'd6, 8'h00, 8'hEE, 2'b10, "lock1_wr6");
        drive(2'b10, 2'b00, 2'b10, 3'd0, 3'd6, 8'h00, 8'h00, 2'b10, "lock1_rd6");
        apply_reset(1);
        drive(2'b11, 2'b00, 2'b00, 3'd6, 3'd3, 8'h00, 8'h00, 2'b01, "post_rst_rd0");
        drive(2'b11, 2'b00, 2'b00, 3'd6, 3'd3, 8'h00, 8'h00, 2'b10, "post_rst_rd1");

        // Read-after-write across requesters
        drive(2'b10, 2'b10, 2'b00, 3'd0, 3'd7, 8'h00, 8'h3C, 2'b10, "wr1_a7");
        drive(2'b01, 2'b00, 2'b00, 3'd7, 3'd0, 8'h00, 8'h00, 2'b01, "raw_rd0");
        drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, "idle1");
        drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, "idle2");
        chk("rsp_hold_raw", rsp_data, 8'h3C);
        chk("sb_drained", 8'(sb.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
